pipeline_sample_driver: RTL and testbench

//  Initiator side of the dsp_pipeline sample handshake (in_sample/in_valid -> ready/out_sample).

---
 rtl/pipeline_sample_driver_if.sv | 37 +++
 rtl/pipeline_sample_driver.sv | 133 +++++++++++++
 tb/tb_pipeline_sample_driver.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_sample_driver_if.sv
// Sample handshake bundle between the ADC/DAC side, the driver and the dsp_pipeline.
// Signal prefixes are from the driver's point of view.
interface pipeline_sample_driver_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CTR_WIDTH  = 16
);
    logic                  i_bypass;
    logic [DATA_WIDTH-1:0] i_adc_sample;
    logic                  i_adc_valid;
    logic [DATA_WIDTH-1:0] o_pipe_in_sample;
    logic                  o_pipe_in_valid;
    logic                  i_pipe_ready;
    logic                  i_pipe_error;
    logic [DATA_WIDTH-1:0] i_pipe_out_sample;
    logic [DATA_WIDTH-1:0] o_dac_sample;
    logic                  o_dac_valid;
    logic                  o_busy;
    logic                  o_timeout_flag;
    logic [CTR_WIDTH-1:0]  o_drop_count;
    logic [CTR_WIDTH-1:0]  o_sample_count;

    modport master (
        input  i_bypass, i_adc_sample, i_adc_valid,
        input  i_pipe_ready, i_pipe_error, i_pipe_out_sample,
        output o_pipe_in_sample, o_pipe_in_valid,
        output o_dac_sample, o_dac_valid, o_busy, o_timeout_flag,
        output o_drop_count, o_sample_count
    );

    modport slave (
        output i_bypass, i_adc_sample, i_adc_valid,
        output i_pipe_ready, i_pipe_error, i_pipe_out_sample,
        input  o_pipe_in_sample, o_pipe_in_valid,
        input  o_dac_sample, o_dac_valid, o_busy, o_timeout_flag,
        input  o_drop_count, o_sample_count
    );
endinterface

// File: rtl/pipeline_sample_driver.sv
// Initiator for the dsp_pipeline sample handshake: buffers one ADC sample, issues it,
// returns the processed result to the DAC, and falls back to pass-through on stall/error.
module pipeline_sample_driver #(
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CTR_WIDTH      = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    pipeline_sample_driver_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]         BUSY_LAST  = 2'd3;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_pending;
    logic [DATA_WIDTH-1:0] r_pipe_in_sample;
    logic                  r_pipe_in_valid;
    logic [DATA_WIDTH-1:0] r_dac_sample;
    logic                  r_dac_valid;
    logic                  r_busy;
    logic                  r_timeout_flag;
    logic [CTR_WIDTH-1:0]  r_drop_count;
    logic [CTR_WIDTH-1:0]  r_sample_count;
    logic [TIMER_W-1:0]    r_timer;
    logic [1:0]            r_busy_cnt;

    logic w_take_bypass;
    logic w_take_pipe;
    logic w_consume;
    logic w_abort;
    logic w_done;
    logic w_finish;

    assign w_take_bypass = (r_state == IDLE) && r_pending && bus.i_bypass;
    assign w_take_pipe   = (r_state == IDLE) && r_pending && !bus.i_bypass
                           && bus.i_pipe_ready && !bus.i_pipe_error;
    assign w_consume     = w_take_bypass || w_take_pipe;

    // Pipeline never dropped ready, or went quiet/errored after dropping it: dry pass-through.
    assign w_abort  = ((r_state == WAIT_BUSY) && bus.i_pipe_ready && (r_busy_cnt == BUSY_LAST))
                   || ((r_state == WAIT_DONE) && (bus.i_pipe_error
                       || (!bus.i_pipe_ready && (r_timer == TIMER_LAST))));
    assign w_done   = (r_state == WAIT_DONE) && !bus.i_pipe_error && bus.i_pipe_ready;
    assign w_finish = w_abort || w_done;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hold       <= '0;
            r_pending    <= 1'b0;
            r_drop_count <= '0;
        end else if (bus.i_adc_valid) begin
            r_hold    <= bus.i_adc_sample;
            r_pending <= 1'b1;
            if (r_pending && !w_consume && (r_drop_count != '1))
                r_drop_count <= r_drop_count + CTR_WIDTH'(1);
        end else if (w_consume) begin
            r_pending <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state          <= IDLE;
            r_busy           <= 1'b0;
            r_pipe_in_sample <= '0;
            r_pipe_in_valid  <= 1'b0;
            r_dac_sample     <= '0;
            r_dac_valid      <= 1'b0;
            r_timeout_flag   <= 1'b0;
            r_sample_count   <= '0;
            r_timer          <= '0;
            r_busy_cnt       <= '0;
        end else begin
            r_pipe_in_valid <= 1'b0;
            r_dac_valid     <= 1'b0;
            if (w_finish) begin
                r_dac_sample   <= w_abort ? r_pipe_in_sample : bus.i_pipe_out_sample;
                r_dac_valid    <= 1'b1;
                r_sample_count <= r_sample_count + CTR_WIDTH'(1);
                if (w_abort)
                    r_timeout_flag <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_take_bypass) begin
                            r_dac_sample   <= r_hold;
                            r_dac_valid    <= 1'b1;
                            r_sample_count <= r_sample_count + CTR_WIDTH'(1);
                        end else if (w_take_pipe) begin
                            r_pipe_in_sample <= r_hold;
                            r_pipe_in_valid  <= 1'b1;
                            r_busy           <= 1'b1;
                            r_state          <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        r_timer    <= '0;
                        r_busy_cnt <= '0;
                        r_state    <= WAIT_BUSY;
                    end
                    WAIT_BUSY: begin
                        r_timer <= r_timer + TIMER_W'(1);
                        if (!bus.i_pipe_ready)
                            r_state <= WAIT_DONE;
                        else
                            r_busy_cnt <= r_busy_cnt + 2'd1;
                    end
                    WAIT_DONE: begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.o_pipe_in_sample = r_pipe_in_sample;
    assign bus.o_pipe_in_valid  = r_pipe_in_valid;
    assign bus.o_dac_sample     = r_dac_sample;
    assign bus.o_dac_valid      = r_dac_valid;
    assign bus.o_busy           = r_busy;
    assign bus.o_timeout_flag   = r_timeout_flag;
    assign bus.o_drop_count     = r_drop_count;
    assign bus.o_sample_count   = r_sample_count;
endmodule

// File: tb/tb_pipeline_sample_driver.sv
// Bench for pipeline_sample_driver: directed scenarios plus randomized traffic against a
// transaction-age reference model, with a behavioural dsp_pipeline responder.
module tb_pipeline_sample_driver;
    localparam int DW = 16;
    localparam int CW = 4;
    localparam int TO = 16;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_issue  = 0;
    int   n_dac    = 0;
    int   n_tick   = 0;

    pipeline_sample_driver_if #(.DATA_WIDTH(DW), .CTR_WIDTH(CW)) bus ();

    pipeline_sample_driver #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .CTR_WIDTH(CW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @tick %0d: got %0h expected %0h", tag, n_tick, got, exp);
        end
    endtask

    // Reference model: one holding slot plus a transaction tracked by its age since issue.
    bit          m_pending, m_active, m_saw_low, m_flag, m_dac_valid, m_in_valid;
    logic [15:0] m_hold, m_dac, m_in_sample;
    int          m_drop, m_count, m_age;

    task automatic model_reset();
        m_pending = 0; m_active = 0; m_saw_low = 0; m_flag = 0;
        m_dac_valid = 0; m_in_valid = 0;
        m_hold = '0; m_dac = '0; m_in_sample = '0;
        m_drop = 0; m_count = 0; m_age = 0;
    endtask

    task automatic model_step();
        bit          consume = 0;
        bit          deliver = 0;
        logic [15:0] dval    = '0;
        m_dac_valid = 0;
        m_in_valid  = 0;
        if (!m_active) begin
            if (m_pending && bus.i_bypass) begin
                deliver = 1; dval = m_hold; consume = 1;
            end else if (m_pending && bus.i_pipe_ready && !bus.i_pipe_error) begin
                m_active = 1; m_age = 0; m_saw_low = 0;
                m_in_sample = m_hold; m_in_valid = 1; consume = 1;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (!m_saw_low) begin
            if (!bus.i_pipe_ready) begin
                m_saw_low = 1; m_age++;
            end else if (m_age == 4) begin
                deliver = 1; dval = m_in_sample; m_flag = 1; m_active = 0;
            end else begin
                m_age++;
            end
        end else begin
            if (bus.i_pipe_error || (!bus.i_pipe_ready && m_age == TO)) begin
                deliver = 1; dval = m_in_sample; m_flag = 1; m_active = 0;
            end else if (bus.i_pipe_ready) begin
                deliver = 1; dval = bus.i_pipe_out_sample; m_active = 0;
            end else begin
                m_age++;
            end
        end
        if (deliver) begin
            m_dac = dval; m_dac_valid = 1;
            m_count = (m_count + 1) % (1 << CW);
        end
        if (bus.i_adc_valid) begin
            if (m_pending && !consume && m_drop < (1 << CW) - 1) m_drop++;
            m_hold = bus.i_adc_sample; m_pending = 1;
        end else if (consume) begin
            m_pending = 0;
        end
    endtask

    // Behavioural pipeline: drops ready the cycle after accepting, result = input >> 3.
    bit          env_busy, env_stuck, env_forever, env_rand_err;
    int          env_lat, env_cnt, env_elapsed, env_err_at;
    logic [15:0] env_data;

    task automatic env_update(input bit acc);
        if (rst) begin
            env_busy = 0; bus.i_pipe_ready = 1; bus.i_pipe_error = 0;
        end else if (acc) begin
            env_data = bus.o_pipe_in_sample >> 3;
            bus.i_pipe_error = 0;
            if (!env_stuck) begin
                env_busy = 1; env_cnt = env_lat; env_elapsed = 0; bus.i_pipe_ready = 0;
            end
        end else if (env_busy) begin
            env_elapsed++;
            bus.i_pipe_error = (env_elapsed == env_err_at);
            if (!env_forever) begin
                env_cnt--;
                if (env_cnt == 0) begin
                    bus.i_pipe_ready = 1; bus.i_pipe_out_sample = env_data; env_busy = 0;
                end
            end
        end else begin
            bus.i_pipe_error = env_rand_err && ($urandom_range(0, 19) == 0);
        end
    endtask

    task automatic tick();
        bit acc;
        acc = bus.o_pipe_in_valid && bus.i_pipe_ready;
        if (rst) model_reset();
        else     model_step();
        @(posedge clk);
        #1;
        n_tick++;
        if (bus.o_pipe_in_valid) n_issue++;
        if (bus.o_dac_valid)     n_dac++;
        check("dac_valid",      bus.o_dac_valid,      m_dac_valid);
        check("dac_sample",     bus.o_dac_sample,     m_dac);
        check("pipe_in_valid",  bus.o_pipe_in_valid,  m_in_valid);
        check("pipe_in_sample", bus.o_pipe_in_sample, m_in_sample);
        check("busy",           bus.o_busy,           m_active);
        check("timeout_flag",   bus.o_timeout_flag,   m_flag);
        check("drop_count",     bus.o_drop_count,     m_drop);
        check("sample_count",   bus.o_sample_count,   m_count);
        env_update(acc);
    endtask

    task automatic do_reset();
        bus.i_adc_valid = 0; bus.i_bypass = 0;
        env_lat = 6; env_stuck = 0; env_forever = 0; env_err_at = -1; env_rand_err = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
        n_issue = 0; n_dac = 0;
    endtask

    task automatic strobe(input logic [15:0] s);
        bus.i_adc_sample = s; bus.i_adc_valid = 1;
        tick();
        bus.i_adc_valid = 0;
    endtask

    task automatic wait_dac(input string tag, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = bus.o_dac_valid;
        end
        check(tag, ok, 1);
    endtask

    task automatic wait_issue(input string tag, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = bus.o_pipe_in_valid;
        end
        check(tag, ok, 1);
    endtask

    initial begin
        int t_issue;
        rst = 1;
        bus.i_adc_sample = '0; bus.i_adc_valid = 0; bus.i_bypass = 0;
        bus.i_pipe_ready = 1; bus.i_pipe_error = 0; bus.i_pipe_out_sample = '0;
        model_reset();

        // Basic transaction through a 6-cycle pipeline
        do_reset();
        check("rst_dac_valid", bus.o_dac_valid, 0);
        check("rst_busy",      bus.o_busy, 0);
        check("rst_counts",    {bus.o_drop_count, bus.o_sample_count}, 0);
        strobe(16'h1234);
        wait_dac("t1_dac_arrive", 40);
        check("t1_dac",    bus.o_dac_sample, 16'h0246);
        check("t1_count",  bus.o_sample_count, 1);
        check("t1_issues", n_issue, 1);
        check("t1_flag",   bus.o_timeout_flag, 0);

        // Overrun: three strobes while the pipeline is busy
        do_reset();
        env_lat = 12;
        strobe(16'h1111);
        repeat (3) tick();
        strobe(16'hA001); tick();
        strobe(16'hA002); tick();
        strobe(16'hA003);
        check("t2_drops", bus.o_drop_count, 2);
        wait_dac("t2_dac1_arrive", 40);
        check("t2_dac1", bus.o_dac_sample, 16'h0222);
        wait_issue("t2_issue2", 10);
        check("t2_newest", bus.o_pipe_in_sample, 16'hA003);
        wait_dac("t2_dac2_arrive", 40);
        check("t2_dac2",   bus.o_dac_sample, 16'h1400);
        check("t2_issues", n_issue, 2);

        // Pipeline never returns ready: timeout abort
        do_reset();
        env_forever = 1;
        strobe(16'h7FFF);
        wait_issue("t3_issue", 5);
        t_issue = n_tick;
        wait_dac("t3_dac_arrive", 40);
        check("t3_latency", n_tick - t_issue, TO + 1);
        check("t3_dac",     bus.o_dac_sample, 16'h7FFF);
        check("t3_flag",    bus.o_timeout_flag, 1);
        env_forever = 0; env_busy = 0; bus.i_pipe_ready = 1;

        // Bypass pass-through
        do_reset();
        bus.i_bypass = 1;
        strobe(16'h8001);
        tick();
        check("t4_dac_valid", bus.o_dac_valid, 1);
        check("t4_dac",       bus.o_dac_sample, 16'h8001);
        repeat (4) tick();
        check("t4_no_issue",  n_issue, 0);
        bus.i_bypass = 0;

        // Pipeline error while waiting for completion
        do_reset();
        env_lat = 10; env_err_at = 3;
        strobe(16'h0F0F);
        wait_dac("t5_dac_arrive", 40);
        check("t5_dac",   bus.o_dac_sample, 16'h0F0F);
        check("t5_flag",  bus.o_timeout_flag, 1);
        check("t5_count", bus.o_sample_count, 1);

        // Reset in the middle of a transaction
        do_reset();
        env_lat = 10;
        strobe(16'h2222);
        repeat (4) tick();
        do_reset();
        check("t6_outputs", {bus.o_dac_valid, bus.o_busy, bus.o_dac_sample, bus.o_pipe_in_sample}, 0);
        repeat (15) tick();
        check("t6_no_dac", n_dac, 0);

        // New strobe in the same cycle the pending sample is consumed
        do_reset();
        env_lat = 4;
        strobe(16'h3333);
        strobe(16'h4444);
        check("t7_issue_a", bus.o_pipe_in_sample, 16'h3333);
        check("t7_drops",   bus.o_drop_count, 0);
        wait_dac("t7_dac_a", 20);
        wait_issue("t7_issue_b", 10);
        check("t7_sample_b", bus.o_pipe_in_sample, 16'h4444);
        check("t7_drops2",   bus.o_drop_count, 0);

        // Randomized traffic
        do_reset();
        env_rand_err = 1;
        for (int c = 0; c < 3000; c++) begin
            if (!env_busy) begin
                env_lat    = $urandom_range(1, 20);
                env_stuck  = ($urandom_range(0, 9) == 0);
                env_err_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, env_lat) : -1;
            end
            if ($urandom_range(0, 39) == 0) bus.i_bypass = ~bus.i_bypass;
            bus.i_adc_valid  = ($urandom_range(0, 5) == 0);
            bus.i_adc_sample = 16'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 0;
        bus.i_adc_valid = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
